// File: rtl/pattgen_if.sv
// rtl/pattgen_if.sv - symbol stream interface (data/valid/ready) for the pattern generator
interface pattgen_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pattgen.sv
// rtl/pattgen.sv - burst pattern generator: ascending/descending range, LFSR, constant, optional CR/LF
module pattgen #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] CHAR_START = DATA_W'(8'h61),
  parameter logic [DATA_W-1:0] CHAR_END   = DATA_W'(8'h7A),
  parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(8'hB8),
  parameter logic [DATA_W-1:0] LFSR_SEED  = DATA_W'(8'h01),
  parameter int                COUNT_W    = 16,
  parameter int                LINE_LEN   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done,
  pattgen_if.master          s
);

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {PH_PAT, PH_CR, PH_LF} phase_e;

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [DATA_W-1:0] SEED = (LFSR_SEED == '0) ? DATA_W'(1) : LFSR_SEED;
  localparam logic [7:0]        LINE_LEN_B = 8'(LINE_LEN);
  localparam logic [DATA_W-1:0] SYM_CR = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] SYM_LF = DATA_W'(8'h0A);

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [1:0]         mode_q, mode_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] beat_q, beat_d;
  logic [7:0]         col_q, col_d;
  logic [DATA_W-1:0]  pat_q, pat_d;
  logic               stop_q, stop_d;
  logic               done_q, done_d;

  logic               beat;
  logic               last_beat;

  function automatic logic [DATA_W-1:0] next_pat(input logic [1:0] md, input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    case (md)
      2'd0:    r = (x == CHAR_END) ? CHAR_START : x + DATA_W'(1);
      2'd1:    r = (x == CHAR_START) ? CHAR_END : x - DATA_W'(1);
      2'd2:    r = x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
      default: r = x;
    endcase
    return r;
  endfunction

  assign beat      = (state_q == S_RUN) && s.ready;
  assign last_beat = (count_q != '0) && ((beat_q + COUNT_W'(1)) == count_q);

  // Next-state: burst launch, per-beat symbol advance, line-break sequencing and burst termination.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    count_d = count_q;
    beat_d  = beat_q;
    col_d   = col_q;
    pat_d   = pat_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          phase_d = PH_PAT;
          mode_d  = mode;
          count_d = count;
          beat_d  = '0;
          col_d   = '0;
          // A stop arriving with start still yields one beat before ending.
          stop_d  = stop;
          case (mode)
            2'd1:    pat_d = CHAR_END;
            2'd2:    pat_d = SEED;
            default: pat_d = CHAR_START;
          endcase
        end
      end
      default: begin
        stop_d = stop_q | stop;
        if (beat) begin
          // Saturate so an endless burst never wraps back onto a finite count.
          if (beat_q != '1) beat_d = beat_q + COUNT_W'(1);
          case (phase_q)
            PH_PAT: begin
              pat_d = next_pat(mode_q, pat_q);
              if (LINE_LEN != 0 && (col_q + 8'd1) == LINE_LEN_B) begin
                phase_d = PH_CR;
                col_d   = '0;
              end else if (LINE_LEN != 0) begin
                col_d = col_q + 8'd1;
              end
            end
            PH_CR:   phase_d = PH_LF;
            default: phase_d = PH_PAT;
          endcase
          if (last_beat || stop_q || stop) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset that abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_PAT;
      mode_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      col_q   <= '0;
      pat_q   <= '0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      col_q   <= col_d;
      pat_q   <= pat_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  // Output symbol: pattern register or CR/LF, held at zero while idle.
  always_comb begin
    s.data = '0;
    if (state_q == S_RUN) begin
      case (phase_q)
        PH_CR:   s.data = SYM_CR;
        PH_LF:   s.data = SYM_LF;
        default: s.data = pat_q;
      endcase
    end
  end

  assign s.valid = (state_q == S_RUN);
  assign busy    = (state_q == S_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_pattgen.sv
// tb/tb_pattgen.sv - randomized and directed self-checking bench for pattgen
module tb_pattgen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ready = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [15:0] count = 16'd0;
  logic        busy_a, done_a, busy_b, done_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pattgen_if #(.DATA_W(8)) if_a ();
  pattgen_if #(.DATA_W(8)) if_b ();
  assign if_a.ready = ready;
  assign if_b.ready = ready;

  pattgen #(.DATA_W(8), .CHAR_START(8'h61), .CHAR_END(8'h63), .LFSR_TAPS(8'hB8),
            .LFSR_SEED(8'h01), .COUNT_W(16), .LINE_LEN(0)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .count(count),
    .busy(busy_a), .done(done_a), .s(if_a));

  pattgen #(.DATA_W(8), .CHAR_START(8'h61), .CHAR_END(8'h63), .LFSR_TAPS(8'hB8),
            .LFSR_SEED(8'h01), .COUNT_W(16), .LINE_LEN(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .count(count),
    .busy(busy_b), .done(done_b), .s(if_b));

  // k-th pattern symbol of a burst, straight from the mode definitions.
  function automatic logic [7:0] pat_k(int md, int k);
    logic [7:0] x;
    case (md)
      0: return 8'h61 + 8'(k % 3);
      1: return 8'h63 - 8'(k % 3);
      2: begin
        x = 8'h01;
        for (int i = 0; i < k; i++) x = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
        return x;
      end
      default: return 8'h61;
    endcase
  endfunction

  // n-th beat of a burst, with CR,LF after every ll pattern symbols.
  function automatic logic [7:0] sym(int md, int ll, int n);
    int per, pos;
    if (ll == 0) return pat_k(md, n);
    per = ll + 2;
    pos = n % per;
    if (pos == ll) return 8'h0D;
    if (pos == ll + 1) return 8'h0A;
    return pat_k(md, (n / per) * ll + pos);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level reference: running flag, beats taken, latched stop.
  bit m_run = 1'b0, m_stp = 1'b0, m_done = 1'b0;
  int m_n = 0, m_cnt = 0, m_mode = 0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_n   = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run  = 1'b1;
        m_n    = 0;
        m_mode = int'(mode);
        m_cnt  = int'(count);
        m_stp  = stop;
      end
    end else begin
      m_stp = m_stp | stop;
      if (ready) begin
        m_n++;
        if ((m_cnt != 0 && m_n == m_cnt) || m_stp) begin
          m_run  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  end

  bit         chk_en = 1'b0;
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];

  // Per-cycle comparison against the reference, plus capture of accepted symbols.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_a", 32'(if_a.valid), 32'(m_run));
      check("busy_a", 32'(busy_a), 32'(m_run));
      check("done_a", 32'(done_a), 32'(m_done));
      check("valid_b", 32'(if_b.valid), 32'(m_run));
      check("busy_b", 32'(busy_b), 32'(m_run));
      check("done_b", 32'(done_b), 32'(m_done));
      if (m_run) begin
        check("data_a", 32'(if_a.data), 32'(sym(m_mode, 0, m_n)));
        check("data_b", 32'(if_b.data), 32'(sym(m_mode, 3, m_n)));
      end
      if (if_a.valid === 1'b1 && ready) got_a.push_back(if_a.data);
      if (if_b.valid === 1'b1 && ready) got_b.push_back(if_b.data);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic launch(int md, int cnt, bit stp);
    got_a.delete();
    got_b.delete();
    mode  = 2'(md);
    count = 16'(cnt);
    start = 1'b1;
    stop  = stp;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (m_run && k < budget) begin
      cyc();
      k++;
    end
    check("burst_end_timeout", 32'(m_run), 32'd0);
  endtask

  task automatic cmp_q(string name, logic [7:0] act[$], logic [7:0] exp[$]);
    check({name, "_len"}, 32'(act.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < act.size(); i++)
      check(name, 32'(act[i]), 32'(exp[i]));
  endtask

  logic [7:0] e[$];
  int         md, cnt, k;

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_valid", 32'(if_a.valid), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_done", 32'(done_a), 32'd0);
    check("reset_data", 32'(if_a.data), 32'd0);

    e = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A, 8'h61, 8'h62};
    for (int i = 0; i < 7; i++) check("model_line", 32'(sym(0, 3, i)), 32'(e[i]));
    e = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    for (int i = 0; i < 4; i++) check("model_lfsr", 32'(sym(2, 0, i)), 32'(e[i]));

    // Ascending burst of 5 at full throughput.
    ready = 1'b1;
    launch(0, 5, 1'b0);
    wait_idle(20);
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd0);
    e = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62};
    cmp_q("t1_seq", got_a, e);
    e = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
    cmp_q("t1_line_seq", got_b, e);
    cyc();

    // Same burst with back-pressure.
    launch(0, 5, 1'b0);
    k = 0;
    while (m_run && k < 40) begin
      ready = (k % 3 == 0) || (k % 3 == 2 && k > 2);
      cyc();
      k++;
    end
    check("t2_timeout", 32'(m_run), 32'd0);
    e = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62};
    cmp_q("t2_seq", got_a, e);
    ready = 1'b1;
    cyc();

    // Descending, line breaks, LFSR.
    launch(1, 4, 1'b0);
    wait_idle(20);
    e = '{8'h63, 8'h62, 8'h61, 8'h63};
    cmp_q("t3_seq", got_a, e);
    launch(0, 7, 1'b0);
    wait_idle(20);
    e = '{8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A, 8'h61, 8'h62};
    cmp_q("t4_seq", got_b, e);
    launch(2, 4, 1'b0);
    wait_idle(20);
    e = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
    cmp_q("t5_seq", got_a, e);

    // Endless burst stopped while stalled.
    launch(0, 0, 1'b0);
    cyc();
    cyc();
    ready = 1'b0;
    stop  = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    cyc();
    check("t6_held_valid", 32'(if_a.valid), 32'd1);
    ready = 1'b1;
    cyc();
    check("t6_done", 32'(done_a), 32'd1);
    check("t6_beats", 32'(got_a.size()), 32'd3);

    // Reset mid-burst, then restart from the range start.
    launch(0, 0, 1'b0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_rst_valid", 32'(if_a.valid), 32'd0);
    check("t6_rst_busy", 32'(busy_a), 32'd0);
    check("t6_rst_done", 32'(done_a), 32'd0);
    launch(0, 3, 1'b0);
    wait_idle(20);
    e = '{8'h61, 8'h62, 8'h63};
    cmp_q("t6_restart", got_a, e);

    // start and stop together: one beat.
    launch(3, 0, 1'b1);
    wait_idle(20);
    check("ss_beats", 32'(got_a.size()), 32'd1);

    // Randomized bursts with back-pressure, stray starts, stops and resets.
    repeat (40) begin
      md  = $urandom_range(0, 3);
      cnt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
      launch(md, cnt, $urandom_range(0, 9) == 0);
      k = 0;
      while (m_run && k < 200) begin
        ready = ($urandom_range(0, 3) != 0);
        stop  = (cnt == 0 && k > 20) ? 1'b1 : ($urandom_range(0, 29) == 0);
        start = ($urandom_range(0, 7) == 0);
        mode  = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) == 0) rst = 1'b1;
        cyc();
        rst   = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        k++;
      end
      check("rand_timeout", 32'(m_run), 32'd0);
      ready = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
